// File: rtl/fetch_module.sv
// Instruction-fetch stage of the LC-3b pipeline: owns the PC, runs the
// instruction-memory read handshake, and feeds decode through the IF/ID
// register, with a one-entry skid buffer for responses that arrive during a
// stall and a drain state for reads left outstanding by a squash.
module fetch_module #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        squash_instruction,
    input  logic [15:0] br_target,
    input  logic        stall,
    output logic        imem_read,
    output logic [15:0] imem_address,
    input  logic        imem_resp,
    input  logic [15:0] imem_rdata,
    output logic        if_valid,
    output logic [15:0] if_ir,
    output logic [15:0] if_pc
);

    typedef enum logic [1:0] {
        START,
        FETCH,
        HOLD,
        DRAIN
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic [15:0] pc_next;
    logic [15:0] fetch_addr;
    logic [15:0] fetch_addr_next;
    logic [15:0] hold_ir;
    logic [15:0] hold_ir_next;
    logic [15:0] hold_pc;
    logic [15:0] hold_pc_next;
    logic        valid_next;
    logic [15:0] ir_next;
    logic [15:0] pc_out_next;

    logic [15:0] target;
    logic [15:0] seq_addr;

    // Redirect targets are halfword aligned; sequential fetch wraps modulo 2^16.
    assign target   = {br_target[15:1], 1'b0};
    assign seq_addr = fetch_addr + 16'd2;

    // State register together with the PC, read address, skid buffer and IF/ID register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= START;
            pc         <= RESET_PC;
            fetch_addr <= RESET_PC;
            hold_ir    <= 16'h0000;
            hold_pc    <= 16'h0000;
            if_valid   <= 1'b0;
            if_ir      <= 16'h0000;
            if_pc      <= 16'h0000;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            fetch_addr <= fetch_addr_next;
            hold_ir    <= hold_ir_next;
            hold_pc    <= hold_pc_next;
            if_valid   <= valid_next;
            if_ir      <= ir_next;
            if_pc      <= pc_out_next;
        end
    end

    // Next-state and datapath update; a squash beats everything, including stall.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        fetch_addr_next = fetch_addr;
        hold_ir_next    = hold_ir;
        hold_pc_next    = hold_pc;
        valid_next      = if_valid;
        ir_next         = if_ir;
        pc_out_next     = if_pc;

        if (squash_instruction) begin
            pc_next     = target;
            valid_next  = 1'b0;
            ir_next     = 16'h0000;
            pc_out_next = 16'h0000;
            case (state)
                START: begin
                    fetch_addr_next = target;
                    state_next      = FETCH;
                end
                FETCH, DRAIN: begin
                    if (imem_resp) begin
                        fetch_addr_next = target;
                        state_next      = FETCH;
                    end else begin
                        state_next = DRAIN;
                    end
                end
                HOLD: begin
                    fetch_addr_next = target;
                    state_next      = FETCH;
                end
                default: state_next = START;
            endcase
        end else begin
            case (state)
                START: begin
                    fetch_addr_next = pc;
                    state_next      = FETCH;
                end
                FETCH: begin
                    if (imem_resp) begin
                        pc_next = seq_addr;
                        if (stall) begin
                            hold_ir_next = imem_rdata;
                            hold_pc_next = seq_addr;
                            state_next   = HOLD;
                        end else begin
                            fetch_addr_next = seq_addr;
                            valid_next      = 1'b1;
                            ir_next         = imem_rdata;
                            pc_out_next     = seq_addr;
                        end
                    end else if (!stall) begin
                        valid_next  = 1'b0;
                        ir_next     = 16'h0000;
                        pc_out_next = 16'h0000;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        valid_next      = 1'b1;
                        ir_next         = hold_ir;
                        pc_out_next     = hold_pc;
                        fetch_addr_next = pc;
                        state_next      = FETCH;
                    end
                end
                DRAIN: begin
                    if (imem_resp) begin
                        fetch_addr_next = pc;
                        state_next      = FETCH;
                    end
                    if (!stall) begin
                        valid_next  = 1'b0;
                        ir_next     = 16'h0000;
                        pc_out_next = 16'h0000;
                    end
                end
                default: state_next = START;
            endcase
        end
    end

    // Memory request is live whenever a read is in flight or being issued.
    always_comb begin
        imem_read    = (state == FETCH) || (state == DRAIN);
        imem_address = fetch_addr;
    end

endmodule

// File: tb/tb_fetch_module.sv
// Testbench for fetch_module: directed walk through fetch, stall/skid, squash,
// drain, wrap-around and asynchronous reset, then a randomized run against a
// stream-level model of the delivered instruction sequence.
module tb_fetch_module;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        squash_instruction;
    logic [15:0] br_target;
    logic        stall;
    logic        imem_read;
    logic [15:0] imem_address;
    logic        imem_resp;
    logic [15:0] imem_rdata;
    logic        if_valid;
    logic [15:0] if_ir;
    logic [15:0] if_pc;

    int errors = 0;
    int checks = 0;

    fetch_module #(.RESET_PC(16'h0000)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .squash_instruction (squash_instruction),
        .br_target          (br_target),
        .stall              (stall),
        .imem_read          (imem_read),
        .imem_address       (imem_address),
        .imem_resp          (imem_resp),
        .imem_rdata         (imem_rdata),
        .if_valid           (if_valid),
        .if_ir              (if_ir),
        .if_pc              (if_pc)
    );

    // Free-running pipeline clock.
    always #5 clk = ~clk;

    // Memory contents used by the randomized run: a fixed scramble of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h9E37;
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkIfid(input string tag, input logic v, input logic [15:0] ir, input logic [15:0] pcv);
        checkOutput({tag, "_valid"}, {15'd0, if_valid}, {15'd0, v});
        checkOutput({tag, "_ir"}, if_ir, ir);
        checkOutput({tag, "_pc"}, if_pc, pcv);
    endtask

    // Drive one cycle of inputs, let a rising edge pass, and settle just after it.
    task automatic applyStimulus(input logic st, input logic sq, input logic [15:0] tgt,
                                 input logic rsp, input logic [15:0] rd);
        stall              = st;
        squash_instruction = sq;
        br_target          = tgt;
        imem_resp          = rsp;
        imem_rdata         = rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic        st;
        logic        sq;
        logic [15:0] tgt;
        logic        rsp;
        logic [15:0] rd;
        logic        busy;
        logic [15:0] lat_addr;
        int          cnt;
        logic [15:0] exp_addr;
        int          delivered;

        reset_n            = 1'b0;
        stall              = 1'b0;
        squash_instruction = 1'b0;
        br_target          = 16'h0000;
        imem_resp          = 1'b0;
        imem_rdata         = 16'h0000;

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        checkIfid("reset", 1'b0, 16'h0000, 16'h0000);
        checkOutput("reset_read", {15'd0, imem_read}, 16'd0);
        reset_n = 1'b1;

        // START -> FETCH at address 0
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("start_read", {15'd0, imem_read}, 16'd1);
        checkOutput("start_addr", imem_address, 16'h0000);

        // Back-to-back fetches
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234);
        checkIfid("fetch0", 1'b1, 16'h1234, 16'h0002);
        checkOutput("fetch0_addr", imem_address, 16'h0002);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5678);
        checkIfid("fetch2", 1'b1, 16'h5678, 16'h0004);
        checkOutput("fetch2_addr", imem_address, 16'h0004);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111);
        checkIfid("fetch4", 1'b1, 16'h1111, 16'h0006);

        // Response under stall goes to the skid buffer
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b1, 16'hABCD);
        checkOutput("hold_read", {15'd0, imem_read}, 16'd0);
        checkIfid("hold_out", 1'b1, 16'h1111, 16'h0006);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkOutput("hold2_read", {15'd0, imem_read}, 16'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkIfid("release", 1'b1, 16'hABCD, 16'h0008);
        checkOutput("release_addr", imem_address, 16'h0008);
        checkOutput("release_read", {15'd0, imem_read}, 16'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222);
        checkIfid("fetch8", 1'b1, 16'h2222, 16'h000A);

        // Squash with read outstanding -> drain, odd target aligned
        applyStimulus(1'b0, 1'b1, 16'h0041, 1'b0, 16'h0000);
        checkOutput("drain_valid", {15'd0, if_valid}, 16'd0);
        checkOutput("drain_addr", imem_address, 16'h000A);
        checkOutput("drain_read", {15'd0, imem_read}, 16'd1);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF);
        checkIfid("drain_discard", 1'b0, 16'h0000, 16'h0000);
        checkOutput("after_drain_addr", imem_address, 16'h0040);

        // Squash coincident with response while stalled
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h4444);
        checkIfid("fetch40", 1'b1, 16'h4444, 16'h0042);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000);
        checkIfid("stall_noresp", 1'b1, 16'h4444, 16'h0042);
        applyStimulus(1'b1, 1'b1, 16'h0100, 1'b1, 16'h3333);
        checkIfid("squash_resp", 1'b0, 16'h0000, 16'h0000);
        checkOutput("squash_resp_addr", imem_address, 16'h0100);

        // Two squashes while draining; the newest target wins
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b1, 16'h0200, 1'b0, 16'h0000);
        checkOutput("dsq1_addr", imem_address, 16'h0100);
        applyStimulus(1'b0, 1'b1, 16'h0300, 1'b0, 16'h0000);
        checkOutput("dsq2_addr", imem_address, 16'h0100);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555);
        checkOutput("dsq_fetch_addr", imem_address, 16'h0300);
        checkIfid("dsq_discard", 1'b0, 16'h0000, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h6666);
        checkIfid("fetch300", 1'b1, 16'h6666, 16'h0302);

        // Wrap-around from FFFE
        applyStimulus(1'b0, 1'b1, 16'hFFFF, 1'b0, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h7777);
        checkOutput("wrap_addr", imem_address, 16'hFFFE);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0E01);
        checkIfid("wrap", 1'b1, 16'h0E01, 16'h0000);
        checkOutput("wrap_next_addr", imem_address, 16'h0000);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b1, 16'h8888);
        checkIfid("fetch_after_wrap", 1'b1, 16'h8888, 16'h0002);

        // Asynchronous reset mid-read
        imem_resp = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checkIfid("async_reset", 1'b0, 16'h0000, 16'h0000);
        checkOutput("async_reset_read", {15'd0, imem_read}, 16'd0);
        checkOutput("async_reset_addr", imem_address, 16'h0000);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Randomized run against the delivered-stream model
        $display("[TB] starting randomized phase");
        busy      = 1'b0;
        lat_addr  = 16'h0000;
        cnt       = 0;
        exp_addr  = 16'h0000;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            st  = ($urandom_range(0, 3) == 0);
            sq  = ($urandom_range(0, 19) == 0);
            tgt = 16'($urandom);

            if (!if_valid)
                checkOutput("rnd_bubble_ir", if_ir, 16'h0000);
            if (!st && !sq && if_valid) begin
                checkOutput("rnd_pc", if_pc, exp_addr + 16'd2);
                checkOutput("rnd_ir", if_ir, mem_word(if_pc - 16'd2));
                exp_addr = if_pc;
                delivered++;
            end
            if (sq)
                exp_addr = tgt & 16'hFFFE;

            rsp = 1'b0;
            rd  = 16'h0000;
            if (busy) begin
                checkOutput("rnd_addr_stable", imem_address, lat_addr);
                checkOutput("rnd_read_held", {15'd0, imem_read}, 16'd1);
            end else if (imem_read) begin
                busy     = 1'b1;
                lat_addr = imem_address;
                cnt      = $urandom_range(0, 2);
            end
            if (busy) begin
                if (cnt == 0) begin
                    rsp  = 1'b1;
                    rd   = mem_word(lat_addr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                end
            end
            applyStimulus(st, sq, tgt, rsp, rd);
        end
        checkOutput("rnd_progress", (delivered > 100) ? 16'd1 : 16'd0, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
